fft_ram_loader: RTL and testbench

FFT_RAM_LOADER -- requirements
Module: fft_ram_loader

---
 rtl/fft_ram_loader_pkg.sv | 16 +
 rtl/fft_ram_loader_if.sv | 34 +++
 rtl/fft_bitrev_index.sv | 19 +
 rtl/fft_ram_loader.sv | 119 +++++++++++
 tb/tb_fft_ram_loader.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_ram_loader_pkg.sv
// Shared FFT defaults and the loader FSM state encoding.
package fft_ram_loader_pkg;

  localparam int FFT_WORDSIZE   = 16;
  localparam int FFT_ADDRSIZE   = 3;
  localparam int FFT_NUMSAMPLES = 32;
  localparam int FFT_NUMSTAGES  = 5;
  localparam int FFT_NUMBANKS   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } load_state_t;

endpackage

// File: rtl/fft_ram_loader_if.sv
// Load handshake, sample stream and four-bank RAM write port of the loader.
interface fft_ram_loader_if
  import fft_ram_loader_pkg::*;
#(
  parameter int WORDSIZE = FFT_WORDSIZE,
  parameter int ADDRSIZE = FFT_ADDRSIZE
);

  logic                ld_data;
  logic                ld_done;
  logic                s_valid;
  logic [WORDSIZE-1:0] s_data;
  logic                s_ready;
  logic                wr_en0, wr_en1, wr_en2, wr_en3;
  logic [ADDRSIZE-1:0] wr_addr0, wr_addr1, wr_addr2, wr_addr3;
  logic [WORDSIZE-1:0] wr_data0, wr_data1, wr_data2, wr_data3;

  modport master (
    output ld_data, s_valid, s_data,
    input  ld_done, s_ready,
    input  wr_en0, wr_en1, wr_en2, wr_en3,
    input  wr_addr0, wr_addr1, wr_addr2, wr_addr3,
    input  wr_data0, wr_data1, wr_data2, wr_data3
  );

  modport slave (
    input  ld_data, s_valid, s_data,
    output ld_done, s_ready,
    output wr_en0, wr_en1, wr_en2, wr_en3,
    output wr_addr0, wr_addr1, wr_addr2, wr_addr3,
    output wr_data0, wr_data1, wr_data2, wr_data3
  );

endinterface

// File: rtl/fft_bitrev_index.sv
// Combinational index reverser; passes the index through unchanged when ENABLE=0.
module fft_bitrev_index #(
  parameter int WIDTH  = 5,
  parameter bit ENABLE = 1'b1
) (
  input  logic [WIDTH-1:0] idx,
  output logic [WIDTH-1:0] idx_out
);

  always_comb begin
    idx_out = idx;
    if (ENABLE) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        idx_out[i] = idx[WIDTH-1-i];
      end
    end
  end

endmodule

// File: rtl/fft_ram_loader.sv
// Streams one frame of samples into four FFT RAM banks, optionally in bit-reversed order.
module fft_ram_loader
  import fft_ram_loader_pkg::*;
#(
  parameter int WORDSIZE   = FFT_WORDSIZE,
  parameter int ADDRSIZE   = FFT_ADDRSIZE,
  parameter int NUMSAMPLES = FFT_NUMSAMPLES,
  parameter int BITREV     = 1
) (
  input logic            clk,
  input logic            rst,
  fft_ram_loader_if.slave bus
);

  localparam int IDXW = ADDRSIZE + 2;
  localparam int CNTW = IDXW + 1;
  localparam logic [CNTW-1:0] LAST = CNTW'(NUMSAMPLES - 1);
  localparam logic [CNTW-1:0] FULL = CNTW'(NUMSAMPLES);

  load_state_t         state;
  logic [CNTW-1:0]     n;
  logic                ready_q;
  logic                done_q;
  logic [3:0]          wr_en_q;
  logic [ADDRSIZE-1:0] wr_addr_q [4];
  logic [WORDSIZE-1:0] wr_data_q [4];

  logic [IDXW-1:0]     j;
  logic [1:0]          bank;
  logic                xfer;

  fft_bitrev_index #(
    .WIDTH  (IDXW),
    .ENABLE (BITREV != 0)
  ) u_bitrev (
    .idx     (n[IDXW-1:0]),
    .idx_out (j)
  );

  assign bank = j[1:0];
  // ready_q is only ever high in LOAD, so it alone qualifies a transfer.
  assign xfer = bus.s_valid & ready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      n       <= '0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
      wr_en_q <= '0;
      for (int unsigned b = 0; b < 4; b++) begin
        wr_addr_q[b] <= '0;
        wr_data_q[b] <= '0;
      end
    end else begin
      wr_en_q <= '0;
      if (xfer) begin
        wr_en_q[bank]   <= 1'b1;
        wr_addr_q[bank] <= j[IDXW-1:2];
        wr_data_q[bank] <= bus.s_data;
      end

      case (state)
        IDLE: begin
          ready_q <= 1'b0;
          done_q  <= 1'b0;
          if (bus.ld_data) begin
            state   <= LOAD;
            n       <= '0;
            ready_q <= 1'b1;
          end
        end
        LOAD: begin
          if (!bus.ld_data) begin
            state   <= IDLE;
            n       <= '0;
            ready_q <= 1'b0;
          end else if (xfer) begin
            n       <= n + CNTW'(1);
            ready_q <= (n != LAST);
          end else if (n == FULL) begin
            // Entered one edge after the last transfer; ld_done follows one edge later.
            state <= DONE;
          end
        end
        DONE: begin
          ready_q <= 1'b0;
          if (!bus.ld_data) begin
            state  <= IDLE;
            done_q <= 1'b0;
          end else begin
            done_q <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          ready_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready  = ready_q;
  assign bus.ld_done  = done_q;
  assign bus.wr_en0   = wr_en_q[0];
  assign bus.wr_en1   = wr_en_q[1];
  assign bus.wr_en2   = wr_en_q[2];
  assign bus.wr_en3   = wr_en_q[3];
  assign bus.wr_addr0 = wr_addr_q[0];
  assign bus.wr_addr1 = wr_addr_q[1];
  assign bus.wr_addr2 = wr_addr_q[2];
  assign bus.wr_addr3 = wr_addr_q[3];
  assign bus.wr_data0 = wr_data_q[0];
  assign bus.wr_data1 = wr_data_q[1];
  assign bus.wr_data2 = wr_data_q[2];
  assign bus.wr_data3 = wr_data_q[3];

endmodule

// File: tb/tb_fft_ram_loader.sv
// Directed bench driving a natural-order and a bit-reversed loader with identical stimulus.
module tb_fft_ram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_data;
  logic        s_valid;
  logic [15:0] s_data;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fft_ram_loader_if #(.WORDSIZE(16), .ADDRSIZE(3)) b0 ();
  fft_ram_loader_if #(.WORDSIZE(16), .ADDRSIZE(3)) b1 ();

  assign b0.ld_data = ld_data;
  assign b0.s_valid = s_valid;
  assign b0.s_data  = s_data;
  assign b1.ld_data = ld_data;
  assign b1.s_valid = s_valid;
  assign b1.s_data  = s_data;

  fft_ram_loader #(.WORDSIZE(16), .ADDRSIZE(3), .NUMSAMPLES(32), .BITREV(0)) dut0 (
    .clk (clk), .rst (rst), .bus (b0.slave)
  );
  fft_ram_loader #(.WORDSIZE(16), .ADDRSIZE(3), .NUMSAMPLES(32), .BITREV(1)) dut1 (
    .clk (clk), .rst (rst), .bus (b1.slave)
  );

  logic [3:0]  en   [2];
  logic [2:0]  ad   [2][4];
  logic [15:0] dt   [2][4];
  logic        done [2];
  logic        rdy  [2];

  always_comb begin
    en[0] = {b0.wr_en3, b0.wr_en2, b0.wr_en1, b0.wr_en0};
    en[1] = {b1.wr_en3, b1.wr_en2, b1.wr_en1, b1.wr_en0};
    ad[0][0] = b0.wr_addr0; ad[0][1] = b0.wr_addr1; ad[0][2] = b0.wr_addr2; ad[0][3] = b0.wr_addr3;
    ad[1][0] = b1.wr_addr0; ad[1][1] = b1.wr_addr1; ad[1][2] = b1.wr_addr2; ad[1][3] = b1.wr_addr3;
    dt[0][0] = b0.wr_data0; dt[0][1] = b0.wr_data1; dt[0][2] = b0.wr_data2; dt[0][3] = b0.wr_data3;
    dt[1][0] = b1.wr_data0; dt[1][1] = b1.wr_data1; dt[1][2] = b1.wr_data2; dt[1][3] = b1.wr_data3;
    done[0] = b0.ld_done; done[1] = b1.ld_done;
    rdy[0]  = b0.s_ready; rdy[1]  = b1.s_ready;
  end

  // RAM image built from observed write strobes.
  logic [15:0] ram  [2][4][8];
  int          hits [2][4][8];
  int          wcount [2];
  int          dual = 0;

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if ($countones(en[d]) > 1) dual++;
      for (int b = 0; b < 4; b++) begin
        if (en[d][b]) begin
          ram[d][b][ad[d][b]] = dt[d][b];
          hits[d][b][ad[d][b]]++;
          wcount[d]++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_n(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  task automatic clear_images();
    for (int d = 0; d < 2; d++) begin
      wcount[d] = 0;
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 8; a++) begin
          ram[d][b][a]  = 16'hFFFF;
          hits[d][b][a] = 0;
        end
    end
    dual = 0;
  endtask

  function automatic int rev5(input int v);
    int r = 0;
    for (int i = 0; i < 5; i++) if (v[i]) r = r | (1 << (4 - i));
    return r;
  endfunction

  task automatic check_zero(input string tag);
    for (int d = 0; d < 2; d++) begin
      check({tag, "_ctl"}, {58'd0, done[d], rdy[d], en[d]}, 64'd0);
      check({tag, "_addr"}, {52'd0, ad[d][3], ad[d][2], ad[d][1], ad[d][0]}, 64'd0);
      check({tag, "_data"}, {dt[d][3], dt[d][2], dt[d][1], dt[d][0]}, 64'd0);
    end
  endtask

  // Full-frame image: sample n lands at natural index n (dut0) or rev5(n) (dut1).
  task automatic check_image(input string tag);
    int bad;
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 8; a++) begin
        check({tag, "_img0"}, 64'(ram[0][b][a]), 64'(4 * a + b));
        check({tag, "_img1"}, 64'(ram[1][b][a]), 64'(rev5(4 * a + b)));
      end
    for (int d = 0; d < 2; d++) begin
      bad = 0;
      for (int b = 0; b < 4; b++)
        for (int a = 0; a < 8; a++) if (hits[d][b][a] != 1) bad++;
      check({tag, "_once"}, 64'(bad), 64'd0);
      check({tag, "_strobes"}, 64'(wcount[d]), 64'd32);
    end
    check({tag, "_onehot"}, 64'(dual), 64'd0);
  endtask

  task automatic burst(input int count, input int base);
    s_valid = 1'b1;
    for (int k = 0; k < count; k++) begin
      s_data = 16'(base + k);
      wait_n(1);
    end
  endtask

  initial begin
    int k;
    int cyc;
    rst = 1'b1; ld_data = 1'b0; s_valid = 1'b0; s_data = '0;
    clear_images();
    wait_n(2);
    check_zero("reset");
    rst = 1'b0;

    // Back-to-back frame with s_data = n
    ld_data = 1'b1; s_valid = 1'b1; s_data = '0;
    wait_n(1);
    check("load_entry_ready", 64'(rdy[0]), 64'd1);
    clear_images();
    burst(32, 0);
    check("last_strobe0", {60'd0, en[0]}, 64'h8);
    check("last_addr0", 64'(ad[0][3]), 64'd7);
    check("last_data0", 64'(dt[0][3]), 64'd31);
    check("last_strobe1", {60'd0, en[1]}, 64'h8);
    check("last_ready", 64'(rdy[0]), 64'd0);
    check("done_edge32", 64'(done[0]), 64'd0);
    s_valid = 1'b0;
    wait_n(1);
    check("done_edge33", {62'd0, done[0], done[1]}, 64'd0);
    wait_n(1);
    check("done_edge34", {62'd0, done[0], done[1]}, 64'h3);
    check_image("seq");
    check("rev_s1", 64'(ram[1][0][4]), 64'd1);
    check("rev_s2", 64'(ram[1][0][2]), 64'd2);
    check("rev_s3", 64'(ram[1][0][6]), 64'd3);
    check("rev_s31", 64'(ram[1][3][7]), 64'd31);

    // DONE held with s_valid asserted; no writes, ld_done stays up
    s_valid = 1'b1;
    wait_n(20);
    check("done_hold", {62'd0, done[0], done[1]}, 64'h3);
    check("done_ready", 64'(rdy[0]), 64'd0);
    check("done_nowrite", 64'(wcount[0] + wcount[1]), 64'd64);
    ld_data = 1'b0;
    wait_n(1);
    check("done_fall", {62'd0, done[0], done[1]}, 64'd0);

    // Immediate re-request, then random valid gaps
    ld_data = 1'b1; s_valid = 1'b0;
    clear_images();
    wait_n(1);
    check("rerequest_ready", 64'(rdy[0]), 64'd1);
    k = 0; cyc = 0;
    while (k < 32 && cyc < 1000) begin
      s_valid = 1'($urandom_range(0, 1));
      if (s_valid && rdy[0]) begin
        s_data = 16'(k);
        k++;
      end else begin
        s_data = 16'hBEEF;
      end
      wait_n(1);
      cyc++;
    end
    check("gap_transfers", 64'(k), 64'd32);
    s_valid = 1'b0;
    wait_n(1);
    check("gap_done_early", 64'(done[0]), 64'd0);
    wait_n(1);
    check("gap_done", {62'd0, done[0], done[1]}, 64'h3);
    check_image("gap");

    // Abort after 10 transfers
    ld_data = 1'b0;
    wait_n(1);
    clear_images();
    ld_data = 1'b1;
    wait_n(1);
    burst(10, 100);
    ld_data = 1'b0; s_valid = 1'b0;
    wait_n(1);
    check("abort_ready", {62'd0, rdy[0], rdy[1]}, 64'd0);
    wait_n(5);
    check("abort_done", {62'd0, done[0], done[1]}, 64'd0);
    check("abort_strobes", 64'(wcount[0]), 64'd10);
    check("abort_s9_nat", 64'(ram[0][1][2]), 64'd109);
    check("abort_s9_rev", 64'(ram[1][2][4]), 64'd109);
    check("abort_s10_none", 64'(ram[0][2][2]), 64'hFFFF);

    // Reload restarts from n=0
    clear_images();
    ld_data = 1'b1;
    wait_n(1);
    burst(32, 200);
    s_valid = 1'b0;
    wait_n(2);
    check("reload_done", 64'(done[0]), 64'd1);
    check("reload_first", 64'(ram[0][0][0]), 64'd200);
    check("reload_s10", 64'(ram[0][2][2]), 64'd210);
    check("reload_strobes", 64'(wcount[0]), 64'd32);

    // Reset while in DONE, then s_valid in IDLE, then reset mid-LOAD
    rst = 1'b1;
    wait_n(1);
    check_zero("rst_done");
    rst = 1'b0; ld_data = 1'b0; s_valid = 1'b1; s_data = 16'h1234;
    clear_images();
    wait_n(5);
    check("idle_ignore", 64'(wcount[0] + wcount[1]), 64'd0);
    ld_data = 1'b1;
    wait_n(1);
    burst(5, 300);
    rst = 1'b1;
    wait_n(1);
    check_zero("rst_load");
    rst = 1'b0; ld_data = 1'b0; s_valid = 1'b0;
    wait_n(2);
    check("post_rst_ready", {62'd0, rdy[0], rdy[1]}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "simulation time limit reached");
  end

endmodule
